// File: rtl/bram_pp_reader.sv
// rtl/bram_pp_reader.sv - drains one ping-pong bank segment into a ready/valid word stream
module bram_pp_reader #(
    parameter int DATA_W          = 32,
    parameter int DEPTH           = 64,
    parameter int ADDR_W          = $clog2(DEPTH),
    parameter int USE_CONS_COMMIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       seg_words,
    output logic              busy,
    output logic              done,
    output logic              consume_req,
    input  logic              consume_busy,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_rdata,
    output logic              cons_commit,
    input  logic              consume_done,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_READ,
        S_CLOSE,
        S_WAIT_REL
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       n_q, n_d;
    logic [31:0]       issued_q, issued_d;
    logic [31:0]       deliv_q, deliv_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sticky_q, sticky_d;
    logic              inflight_q;

    logic [DATA_W-1:0] fifo_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q, count_d;

    logic              push;
    logic              pop;
    logic [2:0]        occ_after_pop;
    logic              last_xfer;

    // Stream side: the FIFO head is always the next word owed downstream.
    always_comb begin
        m_valid       = (count_q != 2'd0);
        m_data        = fifo_q[rd_ptr_q];
        m_last        = m_valid && (deliv_q == n_q - 32'd1);
        pop           = m_valid && m_ready;
        push          = inflight_q;
        count_d       = count_q + {1'b0, push} - {1'b0, pop};
        occ_after_pop = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        last_xfer     = pop && (deliv_q == n_q - 32'd1);
        rd_addr       = rd_en ? issued_q[ADDR_W-1:0] : addr_q;
    end

    // Next-state and control outputs; reads are throttled so the FIFO can never overflow.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        issued_d    = issued_q;
        deliv_d     = deliv_q;
        addr_d      = addr_q;
        sticky_d    = sticky_q;
        busy        = (state_q != S_IDLE);
        done        = 1'b0;
        consume_req = 1'b0;
        rd_en       = 1'b0;
        cons_commit = 1'b0;

        if (pop) begin
            deliv_d = deliv_q + 32'd1;
        end

        // A release arriving before WAIT_REL must not be lost when the buffer closes on its own count.
        if ((USE_CONS_COMMIT == 0) && consume_done &&
            ((state_q == S_READ) || (state_q == S_CLOSE))) begin
            sticky_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d      = (seg_words == 32'd0) ? 32'(DEPTH) : seg_words;
                    issued_d = 32'd0;
                    deliv_d  = 32'd0;
                    sticky_d = 1'b0;
                    state_d  = S_ARM;
                end
            end
            S_ARM: begin
                consume_req = 1'b1;
                if (consume_busy) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if ((issued_q < n_q) && (occ_after_pop < 3'd2)) begin
                    rd_en    = 1'b1;
                    issued_d = issued_q + 32'd1;
                    addr_d   = issued_q[ADDR_W-1:0];
                end
                if (last_xfer) begin
                    state_d = S_CLOSE;
                end
            end
            S_CLOSE: begin
                cons_commit = (USE_CONS_COMMIT != 0);
                state_d     = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (consume_done || sticky_q) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers; reset abandons any segment in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= 32'd0;
            issued_q   <= 32'd0;
            deliv_q    <= 32'd0;
            addr_q     <= '0;
            sticky_q   <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            issued_q   <= issued_d;
            deliv_q    <= deliv_d;
            addr_q     <= addr_d;
            sticky_q   <= sticky_d;
            inflight_q <= rd_en;
        end
    end

    // Two-entry FIFO capturing read data one cycle after each read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= rd_rdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_bram_pp_reader.sv
// tb/tb_bram_pp_reader.sv - randomized self-checking bench for bram_pp_reader
module tb_bram_pp_reader;

    localparam int DEPTH = 64;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]       start_s        = '0;
    logic [1:0][31:0] seg_words_s    = '0;
    logic [1:0]       consume_busy_s = '0;
    logic [1:0]       consume_done_s = '0;
    logic [1:0]       m_ready_s      = 2'b11;
    logic [1:0][31:0] rd_rdata_s     = '0;

    logic [1:0]       busy_s, done_s, consume_req_s, rd_en_s, cons_commit_s;
    logic [1:0]       m_valid_s, m_last_s;
    logic [1:0][5:0]  rd_addr_s;
    logic [1:0][31:0] m_data_s;

    always #5 clk = ~clk;

    // instance 0 releases with cons_commit, instance 1 lets the buffer close on its count
    for (genvar g = 0; g < 2; g++) begin : g_dut
        bram_pp_reader #(
            .DATA_W(32),
            .DEPTH(DEPTH),
            .USE_CONS_COMMIT((g == 0) ? 1 : 0)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .start(start_s[g]),
            .seg_words(seg_words_s[g]),
            .busy(busy_s[g]),
            .done(done_s[g]),
            .consume_req(consume_req_s[g]),
            .consume_busy(consume_busy_s[g]),
            .rd_addr(rd_addr_s[g]),
            .rd_en(rd_en_s[g]),
            .rd_rdata(rd_rdata_s[g]),
            .cons_commit(cons_commit_s[g]),
            .consume_done(consume_done_s[g]),
            .m_valid(m_valid_s[g]),
            .m_data(m_data_s[g]),
            .m_last(m_last_s[g]),
            .m_ready(m_ready_s[g])
        );
    end

    logic [31:0] mem [2][DEPTH];
    int active[2], armed[2], seg_n[2], n_iss[2], n_xfer[2], last_addr[2];
    int req_cnt[2], req_low[2], commits[2], rel_seen[2], seg_done[2], dones[2];
    int first_rd[2], hold_v[2], arm_delay[2], rel_delay[2], rel_wait[2];
    int ready_mode[2], stall[2], hold_start[2], last_done_cyc[2];
    logic [31:0] hold_d[2];
    logic [1:0]       nx_start, nx_cb, nx_cd, nx_ready;
    logic [1:0][31:0] nx_words, nx_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic reset_model(input int g);
        active[g] = 0; armed[g] = 0; seg_n[g] = 0; n_iss[g] = 0; n_xfer[g] = 0;
        last_addr[g] = 0; req_cnt[g] = 0; req_low[g] = 0; commits[g] = 0;
        rel_seen[g] = 0; seg_done[g] = 0; first_rd[g] = -1; hold_v[g] = 0;
        rel_wait[g] = -1; stall[g] = 0; hold_start[g] = 0;
        nx_start[g] = 1'b0; nx_cb[g] = 1'b0; nx_cd[g] = 1'b0; nx_ready[g] = 1'b1;
        nx_words[g] = 32'd0; nx_rdata[g] = $urandom;
    endtask

    task automatic new_seg(input int g, input logic [31:0] words);
        if (hold_start[g] != 0 && last_done_cyc[g] >= 0)
            chk("back_to_back_start", cyc, last_done_cyc[g] + 1);
        seg_n[g] = (words == 32'd0) ? DEPTH : int'(words);
        n_iss[g] = 0; n_xfer[g] = 0; req_cnt[g] = 0; req_low[g] = 0;
        commits[g] = 0; rel_seen[g] = 0; seg_done[g] = 0; first_rd[g] = -1;
        armed[g] = 0; hold_v[g] = 0; rel_wait[g] = -1; active[g] = 1;
        for (int k = 0; k < DEPTH; k++) mem[g][k] = $urandom;
    endtask

    task automatic observe(input int g);
        int use_cc;
        int was_active;
        logic mv, rdy;
        use_cc     = (g == 0) ? 1 : 0;
        was_active = active[g];
        mv         = m_valid_s[g];
        rdy        = m_ready_s[g];
        nx_rdata[g] = $urandom;
        if (was_active == 0) begin
            chk("idle_outputs", {busy_s[g], done_s[g], consume_req_s[g], rd_en_s[g],
                                 cons_commit_s[g], m_valid_s[g], m_last_s[g]}, 32'd0);
            chk("idle_rd_addr", rd_addr_s[g], last_addr[g]);
        end else begin
            chk("busy", busy_s[g], 1);
            chk("consume_req", consume_req_s[g], (armed[g] == 0));
            if (consume_req_s[g]) begin
                req_cnt[g]++;
                if (!consume_busy_s[g]) req_low[g]++;
            end
            if (ready_mode[g] == 0) begin
                chk("rd_en_rate", rd_en_s[g], (armed[g] != 0) && (n_iss[g] < seg_n[g]));
                chk("m_valid_timing", mv, (first_rd[g] >= 0) && (cyc >= first_rd[g] + 2)
                                          && (n_xfer[g] < seg_n[g]));
            end
            if (rd_en_s[g]) begin
                chk("rd_en_legal", (armed[g] != 0) && (n_iss[g] < seg_n[g]), 1);
                chk("rd_addr", rd_addr_s[g], n_iss[g]);
                if (first_rd[g] < 0) first_rd[g] = cyc;
                last_addr[g] = n_iss[g];
                n_iss[g]++;
                nx_rdata[g] = mem[g][rd_addr_s[g]];
                if (use_cc == 0 && n_iss[g] == seg_n[g]) rel_wait[g] = rel_delay[g];
            end else begin
                chk("rd_addr_hold", rd_addr_s[g], last_addr[g]);
            end
            chk("m_last", m_last_s[g], mv && (n_xfer[g] == seg_n[g] - 1));
            if (hold_v[g] != 0) begin
                chk("stall_valid", mv, 1);
                chk("stall_data", m_data_s[g], hold_d[g]);
            end
            if (mv) chk("valid_in_range", n_xfer[g] < seg_n[g], 1);
            if (mv && rdy) begin
                if (n_xfer[g] < seg_n[g]) chk("m_data", m_data_s[g], mem[g][n_xfer[g]]);
                n_xfer[g]++;
            end
            hold_v[g] = (mv && !rdy) ? 1 : 0;
            hold_d[g] = m_data_s[g];
            chk("in_flight_le2", (n_iss[g] - n_xfer[g]) <= 2, 1);
            if (cons_commit_s[g]) begin
                commits[g]++;
                chk("commit_after_last", n_xfer[g], seg_n[g]);
                if (use_cc != 0) rel_wait[g] = rel_delay[g];
            end
            if (consume_done_s[g]) rel_seen[g] = 1;
            if (consume_busy_s[g]) armed[g] = 1;
            if (!consume_busy_s[g] && consume_req_s[g] && req_cnt[g] >= arm_delay[g]) nx_cb[g] = 1'b1;
            if (rel_wait[g] == 0) begin
                nx_cd[g] = 1'b1;
                if (use_cc == 0) rel_wait[g] = -1;
            end else begin
                if (use_cc == 0) nx_cd[g] = 1'b0;
                if (rel_wait[g] > 0) rel_wait[g]--;
            end
            if (done_s[g]) begin
                chk("done_xfers", n_xfer[g], seg_n[g]);
                chk("done_commits", commits[g], use_cc);
                chk("done_released", rel_seen[g], 1);
                seg_done[g] = 1; dones[g]++; last_done_cyc[g] = cyc;
                active[g] = 0; armed[g] = 0; hold_v[g] = 0; rel_wait[g] = -1;
                nx_cb[g] = 1'b0; nx_cd[g] = 1'b0;
            end
        end
        if (start_s[g] && was_active == 0) new_seg(g, seg_words_s[g]);
        if (ready_mode[g] == 0) nx_ready[g] = 1'b1;
        else if (stall[g] > 0) begin nx_ready[g] = 1'b0; stall[g]--; end
        else if ($urandom_range(0, 3) == 0) begin nx_ready[g] = 1'b0; stall[g] = 2; end
        else nx_ready[g] = ($urandom_range(0, 2) != 0);
        nx_start[g] = (hold_start[g] != 0);
        nx_words[g] = (hold_start[g] != 0) ? 32'($urandom_range(0, DEPTH)) : $urandom;
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            if (rst) reset_model(g);
            else observe(g);
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int g = 0; g < 2; g++) begin
            start_s[g]        = nx_start[g];
            seg_words_s[g]    = nx_words[g];
            consume_busy_s[g] = nx_cb[g];
            consume_done_s[g] = nx_cd[g];
            m_ready_s[g]      = nx_ready[g];
            rd_rdata_s[g]     = nx_rdata[g];
        end
    endtask

    task automatic wait_done(input int g, input int budget);
        int k;
        k = 0;
        while (seg_done[g] == 0 && k < budget) begin
            cycle();
            k++;
        end
        chk("done_timeout", seg_done[g], 1);
    endtask

    task automatic run_seg(input int g, input logic [31:0] words);
        start_s[g]     = 1'b1;
        seg_words_s[g] = words;
        cycle();
        wait_done(g, 2000);
    endtask

    task automatic check_reset_outputs(input int g);
        chk("rst_outputs", {busy_s[g], done_s[g], consume_req_s[g], rd_en_s[g],
                            cons_commit_s[g], m_valid_s[g], m_last_s[g]}, 32'd0);
        chk("rst_rd_addr", rd_addr_s[g], 0);
    endtask

    initial begin
        int k;
        int d0;
        for (int g = 0; g < 2; g++) begin
            reset_model(g);
            dones[g] = 0; last_done_cyc[g] = -1; ready_mode[g] = 0;
            arm_delay[g] = 1; rel_delay[g] = 0;
        end
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check_reset_outputs(0);
        check_reset_outputs(1);

        // N=4, free-flowing stream, one commit then release
        arm_delay[0] = 1; rel_delay[0] = 2; ready_mode[0] = 0;
        run_seg(0, 32'd4);
        chk("n4_xfers", n_xfer[0], 4);
        chk("n4_commits", commits[0], 1);

        // seg_words = 0 means a full bank
        run_seg(0, 32'd0);
        chk("depth_xfers", n_xfer[0], DEPTH);
        chk("depth_last_addr", rd_addr_s[0], DEPTH - 1);

        // slow arm handshake
        arm_delay[0] = 5;
        run_seg(0, 32'd3);
        chk("arm_req_low_cycles", req_low[0], 5);

        // random backpressure with 3-cycle stalls
        ready_mode[0] = 1;
        for (int i = 0; i < 6; i++) begin
            arm_delay[0] = $urandom_range(1, 4);
            rel_delay[0] = $urandom_range(0, 3);
            run_seg(0, (i == 0) ? 32'd8 : 32'($urandom_range(0, DEPTH)));
        end

        // buffer closes on its own count; release pulses right after the last read
        ready_mode[1] = 0; arm_delay[1] = 1; rel_delay[1] = 0;
        run_seg(1, 32'd4);
        chk("nocc_xfers", n_xfer[1], 4);
        chk("nocc_commits", commits[1], 0);
        ready_mode[1] = 1;
        for (int i = 0; i < 5; i++) begin
            arm_delay[1] = $urandom_range(1, 3);
            rel_delay[1] = $urandom_range(0, 4);
            run_seg(1, 32'($urandom_range(0, DEPTH)));
        end

        // start held high: ignored alongside done, accepted in the next idle cycle
        ready_mode[0] = 1; arm_delay[0] = 1; rel_delay[0] = 1;
        hold_start[0] = 1; last_done_cyc[0] = -1;
        start_s[0] = 1'b1; seg_words_s[0] = 32'($urandom_range(1, 16));
        d0 = dones[0];
        k = 0;
        while (dones[0] < d0 + 3 && k < 3000) begin
            cycle();
            k++;
        end
        chk("b2b_segments", dones[0] - d0, 3);
        hold_start[0] = 0;
        start_s[0] = 1'b0;
        cycle();

        // reset in the middle of a 6-word segment
        ready_mode[0] = 0; arm_delay[0] = 2;
        start_s[0] = 1'b1; seg_words_s[0] = 32'd6;
        cycle();
        k = 0;
        while (n_xfer[0] < 2 && k < 200) begin
            cycle();
            k++;
        end
        chk("pre_reset_xfers", n_xfer[0], 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_reset_outputs(0);
        check_reset_outputs(1);
        run_seg(0, 32'd5);
        chk("post_reset_xfers", n_xfer[0], 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/bram_pp_reader.md
BRAM_PP_READER -- requirements
Module: bram_pp_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width.
REQ-002 SHALL have parameter DEPTH, default 64, meaning words per bank.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), meaning read address width.
REQ-004 SHALL have parameter USE_CONS_COMMIT, default 1, meaning 1 = issue cons_commit to close a segment, 0 = buffer closes the segment on its rd_en count.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on posedge clk.
REQ-006 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1, meaning pulse that starts reading one segment; ignored unless idle.
REQ-008 SHALL have port seg_words, input, 32, meaning segment length in words; 0 means DEPTH; sampled on accepted start.
REQ-009 SHALL have port busy, output, 1, meaning high from accepted start until done.
REQ-010 SHALL have port done, output, 1, meaning one-cycle pulse when the segment is fully delivered and released.
REQ-011 SHALL have port consume_req, output, 1, meaning request to arm a FULL bank.
REQ-012 SHALL have port consume_busy, input, 1, meaning the buffer has armed a bank.
REQ-013 SHALL have port rd_addr, output, ADDR_W, meaning word read address.
REQ-014 SHALL have port rd_en, output, 1, meaning read strobe.
REQ-015 SHALL have port rd_rdata, input, DATA_W, meaning read data, valid exactly 1 cycle after rd_en.
REQ-016 SHALL have port cons_commit, output, 1, meaning one-cycle segment release pulse.
REQ-017 SHALL have port consume_done, input, 1, meaning buffer reports the bank is released.
REQ-018 SHALL have ports m_valid (output, 1), m_data (output, DATA_W), m_last (output, 1) and m_ready (input, 1), meaning the output stream; transfer = m_valid & m_ready.

Function
REQ-019 SHALL implement FSM states IDLE, ARM, READ, CLOSE, WAIT_REL.
REQ-020 SHALL, in IDLE on start, latch N = (seg_words==0 ? DEPTH : seg_words), clear issue/delivery counters, assert busy and go to ARM.
REQ-021 SHALL hold consume_req high throughout ARM and go to READ in the cycle after consume_busy is sampled high; consume_req SHALL be low in every other state.
REQ-022 SHALL, in READ, assert rd_en with rd_addr = issue count (0..N-1, incrementing by 1 per rd_en) only while issued < N and (buffer occupancy + in-flight reads - pop this cycle) < 2.
REQ-023 SHALL hold rd_addr at its last value when rd_en is low.
REQ-024 SHALL capture rd_rdata into a 2-entry FIFO in the cycle after each rd_en, never dropping or duplicating a word.
REQ-025 SHALL drive m_valid = FIFO not empty and m_data = FIFO head; m_data SHALL be held stable while m_valid & !m_ready.
REQ-026 SHALL assert m_last with the N-th delivered word only.
REQ-027 SHALL sustain 1 word/cycle with m_ready held high; first m_valid 2 cycles after the first rd_en.
REQ-028 SHALL go to CLOSE in the cycle after the N-th transfer.
REQ-029 SHALL, in CLOSE with USE_CONS_COMMIT=1, pulse cons_commit for exactly one cycle, then go to WAIT_REL; with USE_CONS_COMMIT=0, go directly to WAIT_REL with no cons_commit.
REQ-030 SHALL, in WAIT_REL, on consume_done (already high or arriving later), pulse done for one cycle, deassert busy and return to IDLE. With USE_CONS_COMMIT=0, a consume_done that arrived earlier during READ SHALL be remembered in a sticky flag.
REQ-031 SHALL NOT start a new segment from a start that is asserted in the same cycle as done.
REQ-032 SHALL accept start again in the first IDLE cycle after done (back-to-back segments).
REQ-033 SHALL use 32-bit counters and SHALL NOT wrap rd_addr past N-1.

Reset
REQ-034 SHALL, on rst, drive busy, done, consume_req, rd_en, cons_commit, m_valid and m_last to 0 and rd_addr to 0, empty the FIFO, clear all counters and the sticky flag, and enter IDLE.
REQ-035 SHALL apply rst mid-segment by abandoning the segment with no cons_commit; the system resets the ping-pong buffer with the same reset.

Verification
REQ-036 SHALL pass this case: N=4, USE_CONS_COMMIT=1, m_ready=1 -> rd_addr 0,1,2,3 on consecutive cycles, m_data words 0..3 on consecutive cycles, m_last on word 3, one cons_commit, then done after consume_done.
REQ-037 SHALL pass this case: seg_words=0, DEPTH=64 -> exactly 64 transfers, m_last on the 64th, rd_addr ends at 63.
REQ-038 SHALL pass this case: N=8, m_ready toggled randomly with 3-cycle stalls -> in-order, lossless data; no more than 2 words buffered or in flight; m_data stable during stalls.
REQ-039 SHALL pass this case: consume_busy delayed 5 cycles -> consume_req high for those 5 cycles, no rd_en before READ.
REQ-040 SHALL pass this case: USE_CONS_COMMIT=0, N=4, buffer raises consume_done the cycle after the 4th rd_en -> no cons_commit, done after the last transfer.
REQ-041 SHALL pass this case: rst asserted after 2 of 6 transfers -> all outputs at reset values next cycle, and a fresh start then reads from rd_addr 0.
